// File: rtl/pipeline_ctrl_pkg.sv
// Shared stall-bus encodings for the pipeline registers and the stall/flush controller.
// Pure types and constants; no timing or flow-control behaviour of its own.
package pipeline_ctrl_pkg;

  localparam int STALL_W      = 6;
  localparam int STALL_EX_BIT = 3;

  typedef logic [STALL_W-1:0] stall_bus_t;

  // Bit order: [0]pc [1]if_id [2]id [3]id_ex/ex [4]ex_mem [5]mem_wb
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  function automatic stall_bus_t stall_merge(input logic req_if, input logic req_id,
                                             input logic req_mem);
    stall_bus_t s;
    s = STALL_NONE;
    if (req_mem)     s = STALL_MEM;
    else if (req_id) s = STALL_ID;
    else if (req_if) s = STALL_IF;
    return s;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running event counter, increments one cycle after en, wraps modulo 2^CNT_WIDTH.
// Never stalls; the caller folds any global freeze into en.
module perf_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: zero-latency stall bus and flush, registered pending jump, perf counters
// and sticky hang watchdog; rdy_in=0 freezes all state while combinational outputs keep following.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int HANG_LIMIT = 1024
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 stall_req_if,
  input  logic                 stall_req_id,
  input  logic                 stall_req_mem,
  input  logic                 jump_enable_in,
  output logic [STALL_W-1:0]   stall_out,
  output logic                 flush_out,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 hang_out
);

  localparam int HW = $clog2(HANG_LIMIT + 1);
  localparam logic [HW-1:0] HANG_MAX = HW'(HANG_LIMIT);
  localparam logic [HW-1:0] HANG_ARM = HW'(HANG_LIMIT - 1);

  stall_bus_t    stall_raw;
  logic          stalled;
  logic          flush_raw;
  logic          jump_pending_q, jump_pending_d;
  logic          hang_q, hang_d;
  logic [HW-1:0] hang_cnt_q, hang_cnt_d;

  assign stall_raw = stall_merge(stall_req_if, stall_req_id, stall_req_mem);
  assign stalled   = |stall_raw;
  assign flush_raw = jump_enable_in | jump_pending_q;

  // Pipeline registers must see a quiet bus while reset is held.
  assign stall_out = rst_in ? STALL_NONE : stall_raw;
  assign flush_out = ~rst_in & flush_raw;
  assign hang_out  = hang_q;

  always_comb begin
    jump_pending_d = jump_pending_q;
    hang_cnt_d     = hang_cnt_q;
    hang_d         = hang_q;
    if (rdy_in) begin
      // A jump is remembered only while EX is held; it is consumed the cycle EX moves.
      jump_pending_d = stall_raw[STALL_EX_BIT] & (jump_pending_q | jump_enable_in);
      if (stalled) begin
        if (hang_cnt_q != HANG_MAX) hang_cnt_d = hang_cnt_q + HW'(1);
        if (hang_cnt_q == HANG_ARM) hang_d = 1'b1;
      end else begin
        hang_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      jump_pending_q <= 1'b0;
      hang_cnt_q     <= '0;
      hang_q         <= 1'b0;
    end else begin
      jump_pending_q <= jump_pending_d;
      hang_cnt_q     <= hang_cnt_d;
      hang_q         <= hang_d;
    end
  end

  perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk_in(clk_in), .rst_in(rst_in), .en(rdy_in), .count(cycle_cnt)
  );

  perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_in(clk_in), .rst_in(rst_in), .en(rdy_in & stalled), .count(stall_cnt)
  );

  perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_in(clk_in), .rst_in(rst_in), .en(rdy_in & flush_raw), .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl with narrow counters and a short hang limit so wrap and hang are reachable.
module tb_pipeline_ctrl;

  localparam int CW = 4;
  localparam int HL = 8;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          rdy_in = 1'b0;
  logic          s_if = 1'b0, s_id = 1'b0, s_mem = 1'b0, jump = 1'b0;
  logic [5:0]    stall_out;
  logic          flush_out;
  logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic          hang_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: event totals, remembered jump, length of the current stall run, sticky hang.
  int m_cyc, m_stl, m_fls, m_run;
  bit m_pend, m_hang;

  pipeline_ctrl #(.CNT_WIDTH(CW), .HANG_LIMIT(HL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .stall_req_if(s_if), .stall_req_id(s_id), .stall_req_mem(s_mem),
    .jump_enable_in(jump),
    .stall_out(stall_out), .flush_out(flush_out),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .hang_out(hang_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [5:0] ref_stall(input logic i, input logic d, input logic m);
    if (m) return 6'b011111;
    if (d) return 6'b000111;
    if (i) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_stl = 0; m_fls = 0; m_run = 0; m_pend = 0; m_hang = 0;
  endtask

  task automatic drive(input logic r, input logic i, input logic d, input logic m, input logic j);
    rdy_in = r; s_if = i; s_id = d; s_mem = m; jump = j;
    #1;
  endtask

  task automatic tick();
    logic [5:0] s;
    logic       f;
    s = ref_stall(s_if, s_id, s_mem);
    f = jump | m_pend;
    @(posedge clk_in);
    if (!rst_in && rdy_in) begin
      m_cyc = (m_cyc + 1) % (1 << CW);
      if (s != 0) m_stl = (m_stl + 1) % (1 << CW);
      if (f)      m_fls = (m_fls + 1) % (1 << CW);
      m_pend = s[3] ? (m_pend | jump) : 1'b0;
      if (s != 0) begin
        m_run++;
        if (m_run >= HL) m_hang = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    #2 rst_in = 1'b1;
    #1 rst_in = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 1, 1);
    n_tests++; if (stall_out !== 6'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=000000", stall_out); end
    n_tests++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL rst_flush got=%b exp=0", flush_out); end
    n_tests++; if (cycle_cnt !== '0) begin n_fail++; $display("FAIL rst_cycle got=%0d exp=0", cycle_cnt); end
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    tick();
    drive(1, 0, 0, 1, 0);
    repeat (9) tick();
    n_tests++; if (hang_out !== 1'b1) begin n_fail++; $display("FAIL pre_rst_hang got=%b exp=1", hang_out); end
    n_tests++; if (flush_out !== 1'b1) begin n_fail++; $display("FAIL pre_rst_pending got=%b exp=1", flush_out); end
    n_tests++; if (cycle_cnt !== CW'(m_cyc)) begin n_fail++; $display("FAIL pre_rst_cycle got=%0d exp=%0d", cycle_cnt, m_cyc); end
    #1 rst_in = 1'b1;
    #1;
    n_tests++; if ({cycle_cnt, stall_cnt, flush_cnt} !== '0) begin n_fail++;
      $display("FAIL async_rst_cnts got=%0d/%0d/%0d exp=0/0/0", cycle_cnt, stall_cnt, flush_cnt); end
    n_tests++; if (hang_out !== 1'b0) begin n_fail++; $display("FAIL async_rst_hang got=%b exp=0", hang_out); end
    n_tests++; if (stall_out !== 6'b0) begin n_fail++; $display("FAIL async_rst_stall got=%b exp=000000", stall_out); end
    rst_in = 1'b0;
    model_reset();
    drive(1, 0, 0, 0, 0);
    n_tests++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL rst_drops_pending got=%b exp=0", flush_out); end
    tick();
  endtask

  task automatic test_priority();
    logic [3:0] req [5];
    logic [5:0] exp [5];
    req[0] = 4'b1010; exp[0] = 6'b011111;  // {if,id,mem,_}: if+mem
    req[1] = 4'b1000; exp[1] = 6'b000011;
    req[2] = 4'b1100; exp[2] = 6'b000111;
    req[3] = 4'b0110; exp[3] = 6'b011111;
    req[4] = 4'b0000; exp[4] = 6'b000000;
    for (int k = 0; k < 5; k++) begin
      drive(1, req[k][3], req[k][2], req[k][1], 0);
      n_tests++; if (stall_out !== exp[k]) begin n_fail++; $display("FAIL priority_%0d got=%b exp=%b", k, stall_out, exp[k]); end
      tick();
    end
  endtask

  task automatic test_jump_held();
    logic [4:0] exp_f, exp_s3;
    exp_f  = 5'b01111;
    exp_s3 = 5'b00111;
    drive(1, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 0, c < 3, c == 0);
      n_tests++; if (flush_out !== exp_f[c]) begin n_fail++; $display("FAIL held_flush_c%0d got=%b exp=%b", c + 1, flush_out, exp_f[c]); end
      n_tests++; if (stall_out[3] !== exp_s3[c]) begin n_fail++; $display("FAIL held_ex_c%0d got=%b exp=%b", c + 1, stall_out[3], exp_s3[c]); end
      tick();
    end
  endtask

  task automatic test_jump_no_hold();
    for (int k = 0; k < 2; k++) begin
      drive(1, k == 1, k == 0, 0, 1);
      n_tests++; if (flush_out !== 1'b1) begin n_fail++; $display("FAIL nohold_flush_%0d got=%b exp=1", k, flush_out); end
      tick();
      drive(1, k == 1, k == 0, 0, 0);
      n_tests++; if (flush_out !== 1'b0) begin n_fail++; $display("FAIL nohold_pend_%0d got=%b exp=0", k, flush_out); end
      tick();
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    drive(1, 0, 0, 1, 0);
    repeat (HL - 1) tick();
    n_tests++; if (hang_out !== 1'b0) begin n_fail++; $display("FAIL hang_7 got=%b exp=0", hang_out); end
    drive(1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 1, 0);
    repeat (HL) tick();
    n_tests++; if (hang_out !== 1'b1) begin n_fail++; $display("FAIL hang_8 got=%b exp=1", hang_out); end
    drive(1, 0, 0, 0, 0);
    repeat (3) tick();
    n_tests++; if (hang_out !== 1'b1) begin n_fail++; $display("FAIL hang_sticky got=%b exp=1", hang_out); end
    do_reset();
    #1;
    n_tests++; if (hang_out !== 1'b0) begin n_fail++; $display("FAIL hang_clr got=%b exp=0", hang_out); end
  endtask

  task automatic test_rdy_freeze();
    logic [3*CW-1:0] snap;
    do_reset();
    drive(1, 0, 0, 1, 0);
    repeat (5) tick();
    snap = {cycle_cnt, stall_cnt, flush_cnt};
    drive(0, 0, 0, 1, 0);
    repeat (5) tick();
    n_tests++; if ({cycle_cnt, stall_cnt, flush_cnt} !== snap) begin n_fail++; $display("FAIL freeze_cnts got=%h exp=%h", {cycle_cnt, stall_cnt, flush_cnt}, snap); end
    n_tests++; if (stall_out !== 6'b011111) begin n_fail++; $display("FAIL freeze_comb got=%b exp=011111", stall_out); end
    drive(1, 0, 0, 1, 0);
    repeat (2) tick();
    n_tests++; if (hang_out !== 1'b0) begin n_fail++; $display("FAIL freeze_hang7 got=%b exp=0", hang_out); end
    tick();
    n_tests++; if (hang_out !== 1'b1) begin n_fail++; $display("FAIL freeze_hang8 got=%b exp=1", hang_out); end
    do_reset();
    drive(1, 0, 0, 0, 0);
    repeat (15) tick();
    n_tests++; if (cycle_cnt !== 4'hf) begin n_fail++; $display("FAIL wrap_ones got=%h exp=f", cycle_cnt); end
    tick();
    n_tests++; if (cycle_cnt !== 4'h0) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0", cycle_cnt); end
  endtask

  task automatic test_random();
    logic [5:0] es;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(9, 0) != 0, $urandom_range(3, 0) == 0, $urandom_range(4, 0) == 0,
            $urandom_range(5, 0) == 0, $urandom_range(5, 0) == 0);
      es = ref_stall(s_if, s_id, s_mem);
      n_tests++; if (stall_out !== es) begin n_fail++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_out, es); end
      n_tests++; if (flush_out !== (jump | m_pend)) begin n_fail++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, flush_out, jump | m_pend); end
      n_tests++; if (cycle_cnt !== CW'(m_cyc)) begin n_fail++; $display("FAIL rnd_cycle n=%0d got=%0d exp=%0d", n, cycle_cnt, m_cyc); end
      n_tests++; if (stall_cnt !== CW'(m_stl)) begin n_fail++; $display("FAIL rnd_stallcnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_stl); end
      n_tests++; if (flush_cnt !== CW'(m_fls)) begin n_fail++; $display("FAIL rnd_flushcnt n=%0d got=%0d exp=%0d", n, flush_cnt, m_fls); end
      n_tests++; if (hang_out !== m_hang) begin n_fail++; $display("FAIL rnd_hang n=%0d got=%b exp=%b", n, hang_out, m_hang); end
      tick();
      if (n % 100 == 99) do_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_jump_held();
    test_jump_no_hold();
    test_watchdog();
    test_rdy_freeze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
